// File: rtl/peripheral_arbiter_pkg.sv
// peripheral_arbiter_pkg: arbiter FSM state encoding and arbitration mode constants
package peripheral_arbiter_pkg;
   typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, NOOP} state_t;
   localparam logic PRIO_FIXED = 1'b0;
   localparam logic PRIO_RR    = 1'b1;
endpackage

// File: rtl/peripheral_arbiter_picker.sv
// peripheral_arbiter_picker: combinational winner select, fixed (index 0 first) or round-robin from last_winner+1
module peripheral_arbiter_picker
   import peripheral_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 4,
   localparam int LW          = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [LW-1:0]          last_winner,
   input  logic                   mode,
   output logic [NUM_MASTERS-1:0] gnt,
   output logic                   valid
);
   localparam int SW = LW + 1;
   logic [LW-1:0] first;
   logic [SW-1:0] idx;
   assign first = (mode == PRIO_RR && last_winner != LW'(NUM_MASTERS - 1)) ? last_winner + LW'(1) : '0;
   // scan offsets from farthest to nearest so the requester closest to the search start wins
   always_comb begin
      gnt = '0;
      valid = 1'b0;
      idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         idx = SW'(first) + SW'(i);
         idx = (idx >= SW'(NUM_MASTERS)) ? idx - SW'(NUM_MASTERS) : idx;
         if (req[idx[LW-1:0]]) begin
            gnt = '0;
            gnt[idx[LW-1:0]] = 1'b1;
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/peripheral_arbiter.sv
// peripheral_arbiter: UBUS arbiter FSM (IDLE/ARB/ADDR/DATA/NOOP) granting one master per transfer.
// Optional DATA-phase timeout abort is built when PERIPHERAL_ARBITER_TIMEOUT_EN is defined.
module peripheral_arbiter
   import peripheral_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS    = 4,
   parameter  int PRIORITY_MODE  = 0,
   parameter  int TIMEOUT_CYCLES = 64,
   localparam int LW             = $clog2(NUM_MASTERS)
) (
   input  logic                   ubus_clock,
   input  logic                   ubus_reset_n,
   input  logic [NUM_MASTERS-1:0] ubus_req,
   output logic [NUM_MASTERS-1:0] ubus_gnt,
   input  logic                   ubus_bip,
   input  logic                   ubus_wait,
   input  logic                   ubus_error,
   output logic                   ubus_start,
   output logic                   ubus_read,
   output logic                   ubus_write,
   output logic                   ubus_timeout
);
   state_t                 state;
   logic [LW-1:0]          last_winner;
   logic [LW-1:0]          pick_idx;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_valid;
   logic                   rw_drive;
   logic                   timeout_hit;
   logic                   data_done;

   peripheral_arbiter_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req(ubus_req),
      .last_winner(last_winner),
      .mode(PRIORITY_MODE == 1 ? PRIO_RR : PRIO_FIXED),
      .gnt(pick_gnt),
      .valid(pick_valid)
   );

   // index of the one-hot winner, remembered as the next round-robin reference
   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) pick_idx = pick_gnt[i] ? LW'(i) : pick_idx;
   end

`ifdef PERIPHERAL_ARBITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] data_cnt;
   assign timeout_hit = (state == DATA) && (data_cnt == TW'(TIMEOUT_CYCLES - 1));
   // counts completed DATA cycles, cleared on the way into DATA
   always_ff @(posedge ubus_clock) begin
      if (!ubus_reset_n) data_cnt <= '0;
      else if (state == ADDR) data_cnt <= '0;
      else if (state == DATA) data_cnt <= data_cnt + TW'(1);
   end
`else
   assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   assign data_done  = ubus_error || (!ubus_bip && !ubus_wait) || timeout_hit;
   assign ubus_read  = rw_drive ? 1'b0 : 1'bz;
   assign ubus_write = rw_drive ? 1'b0 : 1'bz;

   // arbitration FSM; every bus output is a register updated here
   always_ff @(posedge ubus_clock) begin
      if (!ubus_reset_n) begin
         state        <= IDLE;
         ubus_gnt     <= '0;
         ubus_start   <= 1'b0;
         rw_drive     <= 1'b0;
         ubus_timeout <= 1'b0;
         last_winner  <= LW'(NUM_MASTERS - 1);
      end else begin
         ubus_timeout <= (state == DATA) && timeout_hit && !ubus_error && (ubus_bip || ubus_wait);
         case (state)
            IDLE: begin
               state      <= ARB;
               ubus_start <= 1'b1;
            end
            ARB: begin
               ubus_start <= 1'b0;
               ubus_gnt   <= pick_gnt;
               if (pick_valid) begin
                  state       <= ADDR;
                  last_winner <= pick_idx;
               end else begin
                  state    <= NOOP;
                  rw_drive <= 1'b1;
               end
            end
            ADDR: state <= DATA;
            DATA: if (data_done) begin
               state      <= ARB;
               ubus_start <= 1'b1;
               ubus_gnt   <= '0;
            end
            NOOP: begin
               state      <= ARB;
               ubus_start <= 1'b1;
               rw_drive   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/peripheral_arbiter.md
PERIPHERAL_ARBITER -- requirements
Module: peripheral_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, 4, number of requesting masters (2..16) SHALL be supported.
REQ-002 Parameter PRIORITY_MODE, 0, arbitration mode: 0 = fixed (index 0 highest), 1 = round-robin.
REQ-003 Parameter TIMEOUT_CYCLES, 64, maximum DATA-phase length before forced abort (used only with the macro in REQ-020).
REQ-004 ubus_clock  in  1  single bus clock; all state SHALL change on its rising edge only.
REQ-005 ubus_reset_n  in  1  reset; one clock, synchronous, active-low.
REQ-006 ubus_req  in  NUM_MASTERS  per-master bus request.
REQ-007 ubus_gnt  out  NUM_MASTERS  per-master grant; one-hot or all-zero.
REQ-008 ubus_bip, ubus_wait, ubus_error  in  1 each  burst-in-progress, slave wait, slave error.
REQ-009 ubus_start  out  1  arbitration-phase strobe.
REQ-010 ubus_read, ubus_write  out  1 each  driven 0 during no-op cycles, high-impedance otherwise.
REQ-011 ubus_timeout  out  1  one-cycle pulse on forced DATA abort.

Function
REQ-012 FSM states SHALL be IDLE, ARB, ADDR, DATA, NOOP; every output SHALL be registered.
REQ-013 IDLE: next cycle -> ARB, ubus_start <= 1.
REQ-014 ARB (ubus_start = 1): winner is picked from ubus_req sampled this cycle; any request -> ADDR, ubus_gnt <= one-hot winner, ubus_start <= 0; no request -> NOOP, ubus_gnt <= 0, ubus_read/ubus_write <= 0.
REQ-015 ADDR: unconditionally -> DATA; ubus_gnt held.
REQ-016 DATA: ubus_error = 1 or (ubus_bip = 0 and ubus_wait = 0) -> ARB with ubus_start <= 1 and ubus_gnt <= 0; otherwise stay in DATA, ubus_gnt held.
REQ-017 NOOP: -> ARB, ubus_start <= 1, ubus_read/ubus_write <= Z.
REQ-018 Fixed mode: the lowest requesting index SHALL win. Round-robin mode: search SHALL start at (last_winner + 1) mod NUM_MASTERS and wrap; last_winner updates only on a grant.
REQ-019 A request deasserted after grant SHALL NOT end the transfer; only REQ-016/REQ-020 conditions end DATA.

Reset
REQ-020a ubus_reset_n = 0 at a rising edge SHALL force: state IDLE, ubus_gnt = 0, ubus_start = 0, ubus_read/ubus_write = Z, ubus_timeout = 0, last_winner = NUM_MASTERS-1 (index 0 wins first), timeout counter = 0.
REQ-020b Reset asserted mid-transfer (ADDR/DATA) SHALL drop the grant at that same edge, with no completion cycle.

Configuration
REQ-020 Macro PERIPHERAL_ARBITER_TIMEOUT_EN defined: a counter SHALL clear on DATA entry and increment each DATA cycle; on reaching TIMEOUT_CYCLES the FSM SHALL take the REQ-016 exit and pulse ubus_timeout for one cycle; ubus_error takes precedence when both occur in the same cycle (no timeout pulse).
REQ-021 Macro undefined: no counter is built, ubus_timeout SHALL be tied 0, and DATA SHALL be unbounded.

Structure
REQ-022 Package peripheral_arbiter_pkg SHALL hold the state enum and the PRIORITY_MODE constants (PRIO_FIXED, PRIO_RR).
REQ-023 Sub-module peripheral_arbiter_picker SHALL be a combinational winner selector (req, last_winner, mode -> one-hot, valid).

Verification
REQ-024 Reset release, no requests -> ubus_start pulses every 2nd cycle; ubus_read/ubus_write = 0 in NOOP cycles, Z otherwise; ubus_gnt = 0.
REQ-025 Fixed mode, NUM_MASTERS = 4, ubus_req = 4'b1010 held -> ubus_gnt = 4'b0010 on every arbitration; master 3 is never granted.
REQ-026 Round-robin mode, ubus_req = 4'b1111 held, single-beat transfers -> grant order 0, 1, 2, 3, 0.
REQ-027 Grant to master 2, ubus_wait = 1 for 3 DATA cycles, then ubus_bip = 0 and ubus_wait = 0 -> DATA lasts 4 cycles, then ubus_start = 1 and ubus_gnt = 0 on the next edge.
REQ-028 Macro on, TIMEOUT_CYCLES = 8, ubus_wait stuck at 1 -> exit after 8 DATA cycles with one ubus_timeout pulse; the same case with ubus_error = 1 on cycle 8 gives no pulse.
REQ-029 ubus_reset_n driven low in DATA for 1 cycle -> ubus_gnt = 0 at that edge, state IDLE, and round-robin restarts at master 0.
